// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to revoke grants held MAX_HOLD cycles while another requester waits.
module rr_arbiter #(
    parameter int N = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       request,
    output logic [N-1:0]                       grant,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_id,
    output logic                               busy,
    output logic                               timeout
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    if (N < 1 || N > 16 || MAX_HOLD < 2) begin : g_bad_param
        $error("rr_arbiter: illegal parameters");
    end
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [IW-1:0] ptr, sel_id, nxt_ptr;
    logic own_req, others, revoke;
    int best, d;
    // Pick the requester closest to ptr going upward with wrap.
    always_comb begin
        sel_id = '0;
        best = N;
        d = 0;
        for (int j = 0; j < N; j++) begin
            d = j - int'(ptr);
            d = d < 0 ? d + N : d;
            if (request[j] && d < best) begin
                best = d;
                sel_id = IW'(j);
            end
        end
    end
    assign own_req = |(request & grant);
    assign others  = |(request & ~grant);
    assign nxt_ptr = grant_id == IW'(N - 1) ? '0 : grant_id + IW'(1);
`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] hold_cnt;
    assign revoke = others && hold_cnt >= CW'(MAX_HOLD - 1);
`else
    assign revoke = 1'b0;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            grant_id <= '0;
            busy <= 1'b0;
            ptr <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (state == IDLE) begin
                if (|request) begin
                    state <= BUSY;
                    grant <= N'(1) << sel_id;
                    grant_id <= sel_id;
                    busy <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt <= '0;
`endif
                end
            end else if (!own_req || revoke) begin
                state <= IDLE;
                grant <= '0;
                grant_id <= '0;
                busy <= 1'b0;
                ptr <= nxt_ptr;
`ifdef ARB_TIMEOUT_EN
                timeout <= own_req;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else hold_cnt <= hold_cnt == CW'(MAX_HOLD) ? hold_cnt : hold_cnt + CW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter (N=2, MAX_HOLD=4).
// Stimulus queues expected outputs per edge; a monitor pops and compares after each posedge.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] request = 2'b00;
    logic [1:0] grant;
    logic grant_id, busy, timeout;
    always #5 clk = ~clk;
    rr_arbiter #(.N(2), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .request(request), .grant(grant),
        .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );
    typedef struct packed {
        logic [1:0] g;
        logic       id;
        logic       b;
        logic       t;
    } exp_t;
    exp_t exp_q[$];
    string tag_q[$];
    int checks = 0;
    int errors = 0;
    int grants_seen[2] = '{0, 0};
    bit count_en = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, expected grant=%b id=%0d busy=%b timeout=%b",
                     name, got.g, got.id, got.b, got.t, want.g, want.id, want.b, want.t);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] g, input logic id,
                        input logic b, input logic t, input string name);
        @(negedge clk);
        request = req;
        exp_q.push_back({g, id, b, t});
        tag_q.push_back(name);
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(tag_q.pop_front(), {grant, grant_id, busy, timeout}, e);
            end
            if (count_en && prev_grant == 2'b00 && grant != 2'b00) grants_seen[grant_id]++;
            prev_grant = grant;
        end
    end

    initial begin
        repeat (3) step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, "reset_hold");
        @(negedge clk);
        request = 2'b00;
        rst = 1'b0;
        step(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, "single_grant");
        repeat (10) step(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, "single_hold");
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "single_release");
        step(2'b11, 2'b01, 1'b0, 1'b1, 1'b0, "handover_first");
        step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "handover_gap");
        step(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, "handover_next");
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "handover_release");
        count_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            logic o;
            logic [1:0] og;
            o = 1'(r % 2);
            og = o ? 2'b10 : 2'b01;
            step(2'b11, og, o, 1'b1, 1'b0, "rr_grant");
            repeat (3) step(2'b11, og, o, 1'b1, 1'b0, "rr_hold");
            step(2'b11 & ~og, 2'b00, 1'b0, 1'b0, 1'b0, "rr_gap");
        end
        count_en = 1'b0;
        check_int("rr_count0", grants_seen[0], 4);
        check_int("rr_count1", grants_seen[1], 4);
        step(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, "pre_reset_grant");
        @(negedge clk);
        request = 2'b00;
        #2 rst = 1'b1;
        #1 check("async_reset", {grant, grant_id, busy, timeout}, 5'b0);
        #1 rst = 1'b0;
        exp_q.push_back(5'b0);
        tag_q.push_back("post_reset_idle");
        @(posedge clk);
        step(2'b11, 2'b01, 1'b0, 1'b1, 1'b0, "ptr_reset_grant");
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "ptr_reset_release");
`ifdef ARB_TIMEOUT_EN
        repeat (4) step(2'b11, 2'b10, 1'b1, 1'b1, 1'b0, "to_hold");
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, "to_revoke");
        step(2'b11, 2'b01, 1'b0, 1'b1, 1'b0, "to_next");
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "to_release");
        repeat (8) step(2'b01, 2'b01, 1'b0, 1'b1, 1'b0, "sat_hold");
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, "sat_revoke");
        step(2'b11, 2'b10, 1'b1, 1'b1, 1'b0, "sat_next");
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "sat_release");
`endif
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
